detect_event_logger: RTL and testbench
======================================

Name: detect_event_logger

Overview:
- Downstream consumer of the sequence-detector FSM's 2-bit output code `y`.
- Samples the code on every clock and counts each detection type in saturating counters.
- Records every detection as a {code, timestamp} entry in a small show-ahead FIFO, which the host or testbench drains with a read strobe.
- Provides observability of detector activity without stalling the detector.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- TS_W, 8, timestamp width in bits
- CNT_W, 8, width of each event counter and of the drop counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  sampling enable; when 0, y_in is ignored
- y_in  input  2  detector output code: 00 none, 01 type A, 11 type B, 10 illegal
- clr  input  1  synchronous clear of counters, flags and FIFO
- rd_en  input  1  pop the FIFO head
- fifo_empty  output  1  FIFO holds no entries
- fifo_full  output  1  FIFO holds DEPTH entries
- fifo_level  output  clog2(DEPTH)+1  current entry count
- dout_code  output  2  code of the head entry
- dout_ts  output  TS_W  timestamp of the head entry
- cnt_a  output  CNT_W  number of type-A events
- cnt_b  output  CNT_W  number of type-B events
- drop_cnt  output  CNT_W  events lost because the FIFO was full
- err_flag  output  1  sticky flag: illegal code 10 was seen

Behaviour:
- **Reset.** rst asserted asynchronously sets all state to zero: timestamp counter, cnt_a, cnt_b, drop_cnt, err_flag, FIFO pointers, fifo_level. Outputs while in reset: fifo_empty=1, fifo_full=0, dout_code=00, dout_ts=0. Reset mid-operation discards FIFO contents immediately.
- **Timestamp.** Free-running TS_W counter, +1 every clock, wraps from 2^TS_W-1 to 0. It is not affected by en or clr.
- **Event definition.**
  - An event is a rising edge where en=1, clr=0 and y_in != 00.
  - Each such cycle is one event; there is no edge detection. The detector never holds a nonzero code for consecutive cycles without a new detection.
  - An event's timestamp is the counter value before that edge's increment.
- **Counters.**
  - y_in=01 increments cnt_a; y_in=11 increments cnt_b.
  - Both saturate at 2^CNT_W-1 and never wrap.
- **Illegal code.** y_in=10 sets err_flag, which holds until clr or rst. The event is still pushed with code 10 and does not touch cnt_a or cnt_b.
- **FIFO organisation.** Show-ahead: dout_code and dout_ts always present the oldest entry and update the cycle after a pop or after the first push into an empty FIFO. When empty, dout holds its last value.
- **FIFO operations.**
  - Pop: rd_en=1 and not empty removes the head at the edge. rd_en while empty is ignored with no error.
  - Push: an event is written if not full, or if full and a pop occurs in the same cycle. Pop is evaluated first, so the level is unchanged.
  - Drop: an event arriving while full with no pop is discarded, and drop_cnt increments (saturating).
  - Empty with simultaneous push and rd_en: the push is accepted, the pop is ignored, and the level becomes 1.
- **Pointers and flags.** Pointers wrap modulo DEPTH. fifo_level, fifo_full and fifo_empty are registered and consistent with the pointers in the same cycle.
- **clr.**
  - Zeroes cnt_a, cnt_b, drop_cnt, err_flag and the FIFO pointers/level at the edge.
  - Has priority over a coincident event (the event is lost, not counted as dropped) and over rd_en.
- **Latency.** An event at edge N is visible at dout and in the counters after edge N, when the FIFO was empty beforehand.
- **Structure.**
  - No combinational path from y_in or rd_en to any output.
  - All sequential logic is on posedge clk with asynchronous reset.

Test Plan:
1. **Reset and idle.** Assert rst, release, hold y_in=00 for 10 cycles → fifo_empty=1, all counters 0, err_flag=0; timestamp reaches 10 (observed via a later event).
2. **Single event latency.** After reset release, y_in=01 for one cycle at the edge where the timestamp is 5 → next cycle fifo_level=1, dout_code=01, dout_ts=5, cnt_a=1. Then rd_en=1 for one cycle → fifo_empty=1.
3. **Overflow and drop.** Push 6 events (alternating 01/11) with DEPTH=4 and no reads → fifo_full=1, level=4, drop_cnt=2, cnt_a=3, cnt_b=3. Drain with 4 reads → head codes 01,11,01,11 in order, with strictly increasing timestamps.
4. **Full with simultaneous push and pop.** When full, y_in=11 with rd_en=1 → level stays 4, drop_cnt unchanged, the new entry becomes the tail. Empty with push and rd_en=1 → level=1.
5. **Illegal code, clr and saturation.**
   - y_in=10 → err_flag=1, an entry with code 10 is pushed, cnt_a and cnt_b unchanged.
   - clr=1 together with y_in=01 → everything zero next cycle, cnt_a=0.
   - With CNT_W=2, 5 type-A events → cnt_a=3.
6. **Asynchronous reset and wrap.**
   - rst asserted mid-cycle with 3 entries queued → fifo_empty=1 before the next clk edge.
   - With TS_W=4, an event at cycle 17 after reset → dout_ts=1.

Source files
------------

// File: rtl/detect_event_logger.sv
// Event logger for the sequence detector: counts detection types and
// queues {code, timestamp} records in a show-ahead FIFO drained by rd_en.
module detect_event_logger #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               y_in,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [1:0]               dout_code,
    output logic [TS_W-1:0]          dout_ts,
    output logic [CNT_W-1:0]         cnt_a,
    output logic [CNT_W-1:0]         cnt_b,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     err_flag
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [TS_W-1:0] ts;
    logic [1:0]      mem_code [DEPTH];
    logic [TS_W-1:0] mem_ts   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_nxt;
    logic [LW-1:0]   lvl_nxt;

    logic ev;
    logic pop;
    logic push;
    logic drop;

    // Pop is resolved before push so a full FIFO can accept a write
    // in the same cycle it is read.
    always_comb begin
        ev     = en && !clr && (y_in != 2'b00);
        pop    = rd_en && !fifo_empty && !clr;
        push   = ev && (!fifo_full || pop);
        drop   = ev && fifo_full && !pop;
        rd_nxt = rd_ptr + PW'(1);
        lvl_nxt = fifo_level;
        if (push && !pop)
            lvl_nxt = fifo_level + LW'(1);
        else if (pop && !push)
            lvl_nxt = fifo_level - LW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts         <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            drop_cnt   <= '0;
            err_flag   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            dout_code  <= 2'b00;
            dout_ts    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_code[i] <= 2'b00;
                mem_ts[i]   <= '0;
            end
        end else begin
            ts <= ts + TS_W'(1);
            if (clr) begin
                cnt_a      <= '0;
                cnt_b      <= '0;
                drop_cnt   <= '0;
                err_flag   <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_level <= '0;
                fifo_empty <= 1'b1;
                fifo_full  <= 1'b0;
            end else begin
                if (ev && y_in == 2'b01 && cnt_a != '1)
                    cnt_a <= cnt_a + CNT_W'(1);
                if (ev && y_in == 2'b11 && cnt_b != '1)
                    cnt_b <= cnt_b + CNT_W'(1);
                if (ev && y_in == 2'b10)
                    err_flag <= 1'b1;
                if (drop && drop_cnt != '1)
                    drop_cnt <= drop_cnt + CNT_W'(1);
                if (push) begin
                    mem_code[wr_ptr] <= y_in;
                    mem_ts[wr_ptr]   <= ts;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_nxt;
                fifo_level <= lvl_nxt;
                fifo_empty <= (lvl_nxt == '0);
                fifo_full  <= (lvl_nxt == LW'(DEPTH));
                // Registered head: pick what will be oldest after this edge
                if (pop) begin
                    if (fifo_level > LW'(1)) begin
                        dout_code <= mem_code[rd_nxt];
                        dout_ts   <= mem_ts[rd_nxt];
                    end else if (push) begin
                        dout_code <= y_in;
                        dout_ts   <= ts;
                    end
                end else if (push && fifo_empty) begin
                    dout_code <= y_in;
                    dout_ts   <= ts;
                end
            end
        end
    end

endmodule

// File: tb/tb_detect_event_logger.sv
// Directed bench for detect_event_logger (DEPTH=4, TS_W=4, CNT_W=2).
module tb_detect_event_logger;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] y_in;
    logic       clr;
    logic       rd_en;
    logic       fifo_empty;
    logic       fifo_full;
    logic [2:0] fifo_level;
    logic [1:0] dout_code;
    logic [3:0] dout_ts;
    logic [1:0] cnt_a;
    logic [1:0] cnt_b;
    logic [1:0] drop_cnt;
    logic       err_flag;

    int checks = 0;
    int errors = 0;
    logic [3:0] ts_m;
    logic [3:0] exp_ts [6];
    logic [3:0] last_ts;

    detect_event_logger #(
        .DEPTH(4),
        .TS_W (4),
        .CNT_W(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .y_in      (y_in),
        .clr       (clr),
        .rd_en     (rd_en),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_level(fifo_level),
        .dout_code (dout_code),
        .dout_ts   (dout_ts),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .drop_cnt  (drop_cnt),
        .err_flag  (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        ts_m = ts_m + 4'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; y_in = 2'b00; clr = 1'b0; rd_en = 1'b0;
        ts_m = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        ts_m = 4'd0;

        // Reset state
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_code", 32'(dout_code), 32'd0);
        chk("rst_ts", 32'(dout_ts), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);

        // Idle 10 cycles then a single type-A event at timestamp 10
        en = 1'b1;
        repeat (10) tick();
        chk("idle_empty", 32'(fifo_empty), 32'd1);
        y_in = 2'b01;
        tick();
        y_in = 2'b00;
        chk("single_level", 32'(fifo_level), 32'd1);
        chk("single_code", 32'(dout_code), 32'd1);
        chk("single_ts", 32'(dout_ts), 32'd10);
        chk("single_cnt_a", 32'(cnt_a), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("single_pop_empty", 32'(fifo_empty), 32'd1);
        chk("single_pop_level", 32'(fifo_level), 32'd0);

        // Overflow: six alternating events into a 4-deep FIFO
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            y_in = (i % 2 == 0) ? 2'b01 : 2'b11;
            exp_ts[i] = ts_m;
            tick();
        end
        y_in = 2'b00;
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_cnt_a", 32'(cnt_a), 32'd3);
        chk("ovf_cnt_b", 32'(cnt_b), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("drain_code", 32'(dout_code),
                (i % 2 == 0) ? 32'd1 : 32'd3);
            chk("drain_ts", 32'(dout_ts), 32'(exp_ts[i]));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);

        // Full with simultaneous push and pop
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            y_in = 2'b01;
            exp_ts[i] = ts_m;
            tick();
        end
        y_in = 2'b11;
        rd_en = 1'b1;
        last_ts = ts_m;
        tick();
        y_in = 2'b00;
        rd_en = 1'b0;
        chk("fpp_level", 32'(fifo_level), 32'd4);
        chk("fpp_full", 32'(fifo_full), 32'd1);
        chk("fpp_drop", 32'(drop_cnt), 32'd0);
        chk("fpp_head_ts", 32'(dout_ts), 32'(exp_ts[1]));
        for (int i = 1; i < 4; i++) begin
            chk("fpp_code", 32'(dout_code), 32'd1);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        chk("fpp_tail_code", 32'(dout_code), 32'd3);
        chk("fpp_tail_ts", 32'(dout_ts), 32'(last_ts));
        rd_en = 1'b1;
        tick();
        chk("fpp_empty", 32'(fifo_empty), 32'd1);
        y_in = 2'b01;
        tick();
        y_in = 2'b00;
        rd_en = 1'b0;
        chk("epp_level", 32'(fifo_level), 32'd1);
        chk("epp_code", 32'(dout_code), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("epp_pop_empty", 32'(fifo_empty), 32'd1);

        // Illegal code, clr priority, saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        y_in = 2'b10;
        tick();
        y_in = 2'b00;
        chk("ill_err", 32'(err_flag), 32'd1);
        chk("ill_level", 32'(fifo_level), 32'd1);
        chk("ill_code", 32'(dout_code), 32'd2);
        chk("ill_cnt_a", 32'(cnt_a), 32'd0);
        chk("ill_cnt_b", 32'(cnt_b), 32'd0);
        tick();
        chk("ill_sticky", 32'(err_flag), 32'd1);
        clr = 1'b1;
        y_in = 2'b01;
        rd_en = 1'b1;
        tick();
        clr = 1'b0;
        y_in = 2'b00;
        rd_en = 1'b0;
        chk("clr_level", 32'(fifo_level), 32'd0);
        chk("clr_empty", 32'(fifo_empty), 32'd1);
        chk("clr_err", 32'(err_flag), 32'd0);
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        y_in = 2'b01;
        repeat (5) tick();
        y_in = 2'b00;
        chk("sat_cnt_a", 32'(cnt_a), 32'd3);
        chk("sat_drop", 32'(drop_cnt), 32'd1);
        chk("sat_full", 32'(fifo_full), 32'd1);

        // Asynchronous reset mid-cycle, then timestamp wrap
        clr = 1'b1;
        tick();
        clr = 1'b0;
        y_in = 2'b11;
        repeat (3) tick();
        y_in = 2'b00;
        chk("pre_rst_level", 32'(fifo_level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_empty", 32'(fifo_empty), 32'd1);
        chk("async_level", 32'(fifo_level), 32'd0);
        chk("async_code", 32'(dout_code), 32'd0);
        chk("async_ts", 32'(dout_ts), 32'd0);
        chk("async_cnt_b", 32'(cnt_b), 32'd0);
        #2;
        rst = 1'b0;
        ts_m = 4'd0;
        repeat (17) tick();
        y_in = 2'b01;
        tick();
        y_in = 2'b00;
        chk("wrap_ts", 32'(dout_ts), 32'd1);
        chk("wrap_code", 32'(dout_code), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
